// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: four-approach intersection phase scheduler.
// Round-robin grant of a single green phase, with minimum-green, gap-out and
// max-out timing, followed by yellow and all-red clearance.
// Optional feature macro: TRAFFIC_FLASH_EN (en low -> flashing yellow).
// Ports:
//   clk    : clock, rising edge
//   res_n  : synchronous active-low reset
//   en     : run enable
//   req    : level request per approach
//   green  : one-hot green lamp (or zero)
//   yellow : yellow lamps
//   red    : red lamps
//   phase  : index of the approach most recently granted
//   busy   : high in GREEN, YELLOW or ALLRED
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned FLASH_T   = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] phase,
  output logic       busy
);

  localparam logic [7:0] GMIN_M1 = 8'(GREEN_MIN - 1);
  localparam logic [7:0] GMAX_M1 = 8'(GREEN_MAX - 1);
  localparam logic [7:0] YEL_M1  = 8'(YELLOW_T - 1);
  localparam logic [7:0] AR_M1   = 8'(ALLRED_T - 1);

`ifdef TRAFFIC_FLASH_EN
  localparam logic [7:0] FLASH_M1 = 8'(FLASH_T - 1);
  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt, timer_inc;
  logic [1:0] phase_nxt, pick;
  logic [3:0] green_nxt, yellow_nxt, red_nxt;
  logic       busy_nxt, any_req, contested;
`ifdef TRAFFIC_FLASH_EN
  logic       lit, lit_nxt;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // First requester scanning upward from cur+1; cur itself is scanned last.
  function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = cur;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    phase_nxt = phase;
`ifdef TRAFFIC_FLASH_EN
    lit_nxt   = lit;
`endif
    any_req   = |req;
    contested = |(req & ~onehot(phase));
    pick      = rr_pick(phase, req);
    timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;

    if (!en) begin
`ifdef TRAFFIC_FLASH_EN
      if (state != S_FLASH) begin
        state_nxt = S_FLASH;
        timer_nxt = '0;
        lit_nxt   = 1'b1;
      end else if (timer == FLASH_M1) begin
        timer_nxt = '0;
        lit_nxt   = ~lit;
      end else begin
        timer_nxt = timer + 8'd1;
      end
`endif
    end else begin
      timer_nxt = timer_inc;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state_nxt = S_GREEN;
            phase_nxt = pick;
            timer_nxt = '0;
          end
        end
        S_GREEN: begin
          if (timer >= GMIN_M1 && contested && (!req[phase] || timer >= GMAX_M1)) begin
            state_nxt = S_YELLOW;
            timer_nxt = '0;
          end
        end
        S_YELLOW: begin
          if (timer == YEL_M1) begin
            state_nxt = S_ALLRED;
            timer_nxt = '0;
          end
        end
        S_ALLRED: begin
          if (timer == AR_M1) begin
            timer_nxt = '0;
            if (any_req) begin
              state_nxt = S_GREEN;
              phase_nxt = pick;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
`ifdef TRAFFIC_FLASH_EN
        S_FLASH: begin
          state_nxt = S_ALLRED;
          timer_nxt = '0;
        end
`endif
        default: begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end
      endcase
    end

    // Lamps are derived from the next state so that every output is registered.
    green_nxt  = '0;
    yellow_nxt = '0;
    busy_nxt   = 1'b0;
    case (state_nxt)
      S_GREEN: begin
        green_nxt = onehot(phase_nxt);
        busy_nxt  = 1'b1;
      end
      S_YELLOW: begin
        yellow_nxt = onehot(phase_nxt);
        busy_nxt   = 1'b1;
      end
      S_ALLRED: busy_nxt = 1'b1;
      default:  busy_nxt = 1'b0;
    endcase
    red_nxt = ~(green_nxt | yellow_nxt);
`ifdef TRAFFIC_FLASH_EN
    if (state_nxt == S_FLASH) begin
      red_nxt    = '0;
      yellow_nxt = lit_nxt ? 4'hF : 4'h0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state  <= S_IDLE;
      timer  <= '0;
      phase  <= 2'd3;
      green  <= '0;
      yellow <= '0;
      red    <= '1;
      busy   <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
      lit    <= 1'b1;
`endif
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      phase  <= phase_nxt;
      green  <= green_nxt;
      yellow <= yellow_nxt;
      red    <= red_nxt;
      busy   <= busy_nxt;
`ifdef TRAFFIC_FLASH_EN
      lit    <= lit_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler (default parameters).
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       res_n, en;
  logic [3:0] req;
  logic [3:0] green, yellow, red;
  logic [1:0] phase;
  logic       busy;

  traffic_phase_scheduler #(
    .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(4)
  ) dut (
    .clk(clk), .res_n(res_n), .en(en), .req(req),
    .green(green), .yellow(yellow), .red(red), .phase(phase), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rn;
    logic       e;
    logic [3:0] rq;
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [1:0] ph;
    logic       b;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;

  // Queue one cycle: stimulus plus the outputs expected after the next edge.
  function automatic void push(input logic rn, input logic e, input logic [3:0] rq,
                               input logic [3:0] g, input logic [3:0] y,
                               input logic [1:0] ph, input logic b);
    item_t it;
    it = '{rn: rn, e: e, rq: rq, g: g, y: y, r: ~(g | y), ph: ph, b: b};
    sb.push_back(it);
  endfunction

  function automatic void push_r(input logic rn, input logic e, input logic [3:0] rq,
                                 input logic [3:0] g, input logic [3:0] y, input logic [3:0] r,
                                 input logic [1:0] ph, input logic b);
    item_t it;
    it = '{rn: rn, e: e, rq: rq, g: g, y: y, r: r, ph: ph, b: b};
    sb.push_back(it);
  endfunction

  task automatic apply(input item_t it);
    res_n = it.rn;
    en    = it.e;
    req   = it.rq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    push(0, 1, 4'hF, 4'h0, 4'h0, 2'd3, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL reset step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

  task automatic test_hold();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    repeat (30) push(1, 1, 4'b0001, 4'b0001, 4'h0, 2'd0, 1);
    repeat (3)  push(1, 1, 4'b0000, 4'b0001, 4'h0, 2'd0, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL hold step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

  task automatic test_maxout();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    push(1, 1, 4'b0001, 4'b0001, 4'h0, 2'd0, 1);
    repeat (9) push(1, 1, 4'b0101, 4'b0001, 4'h0, 2'd0, 1);
    repeat (2) push(1, 1, 4'b0101, 4'h0, 4'b0001, 2'd0, 1);
    push(1, 1, 4'b0101, 4'h0, 4'h0, 2'd0, 1);
    repeat (2) push(1, 1, 4'b0101, 4'b0100, 4'h0, 2'd2, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL maxout step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

  task automatic test_gapout();
    item_t it;
    int unsigned n = 0;
    // Early drop: minimum green still enforced.
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    repeat (2) push(1, 1, 4'b0011, 4'b0001, 4'h0, 2'd0, 1);
    repeat (2) push(1, 1, 4'b0010, 4'b0001, 4'h0, 2'd0, 1);
    repeat (2) push(1, 1, 4'b0010, 4'h0, 4'b0001, 2'd0, 1);
    push(1, 1, 4'b0010, 4'h0, 4'h0, 2'd0, 1);
    push(1, 1, 4'b0010, 4'b0010, 4'h0, 2'd1, 1);
    // Late drop: yellow on the next cycle.
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    repeat (7) push(1, 1, 4'b0011, 4'b0001, 4'h0, 2'd0, 1);
    repeat (2) push(1, 1, 4'b0010, 4'h0, 4'b0001, 2'd0, 1);
    push(1, 1, 4'b0010, 4'h0, 4'h0, 2'd0, 1);
    push(1, 1, 4'b0010, 4'b0010, 4'h0, 2'd1, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL gapout step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    item_t it;
    int unsigned n = 0;
    logic [3:0] oh;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    for (int a = 0; a < 4; a++) begin
      oh = 4'b0001 << a;
      repeat (10) push(1, 1, 4'hF, oh, 4'h0, 2'(a), 1);
      repeat (2)  push(1, 1, 4'hF, 4'h0, oh, 2'(a), 1);
      push(1, 1, 4'hF, 4'h0, 4'h0, 2'(a), 1);
    end
    repeat (3) push(1, 1, 4'hF, 4'b0001, 4'h0, 2'd0, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL back_to_back step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

`ifndef TRAFFIC_FLASH_EN
  task automatic test_freeze();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    push(1, 1, 4'b0011, 4'b0001, 4'h0, 2'd0, 1);
    repeat (3) push(1, 1, 4'b0010, 4'b0001, 4'h0, 2'd0, 1);
    push(1, 1, 4'b0010, 4'h0, 4'b0001, 2'd0, 1);
    repeat (5) push(1, 0, 4'b0010, 4'h0, 4'b0001, 2'd0, 1);
    push(1, 1, 4'b0010, 4'h0, 4'b0001, 2'd0, 1);
    push(1, 1, 4'b0010, 4'h0, 4'h0, 2'd0, 1);
    push(1, 1, 4'b0010, 4'b0010, 4'h0, 2'd1, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL freeze step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask
`else
  task automatic test_flash();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    push(1, 1, 4'b0010, 4'b0010, 4'h0, 2'd1, 1);
    repeat (4) push_r(1, 0, 4'b0010, 4'h0, 4'hF, 4'h0, 2'd1, 0);
    repeat (4) push_r(1, 0, 4'b0010, 4'h0, 4'h0, 4'h0, 2'd1, 0);
    repeat (4) push_r(1, 0, 4'b0010, 4'h0, 4'hF, 4'h0, 2'd1, 0);
    push(1, 1, 4'b0010, 4'h0, 4'h0, 2'd1, 1);
    push(1, 1, 4'b0010, 4'b0010, 4'h0, 2'd1, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL flash step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    item_t it;
    int unsigned n = 0;
    push(0, 0, 4'h0, 4'h0, 4'h0, 2'd3, 0);
    push(1, 1, 4'b0110, 4'b0010, 4'h0, 2'd1, 1);
    repeat (3) push(1, 1, 4'b0100, 4'b0010, 4'h0, 2'd1, 1);
    push(1, 1, 4'b0100, 4'h0, 4'b0010, 2'd1, 1);
    push(0, 1, 4'b0111, 4'h0, 4'h0, 2'd3, 0);
    push(1, 1, 4'b0111, 4'b0001, 4'h0, 2'd0, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++; n++;
      if ({green, yellow, red, phase, busy} !== {it.g, it.y, it.r, it.ph, it.b}) begin
        bad++;
        $display("FAIL reset_mid step=%0d got g=%b y=%b r=%b ph=%0d busy=%b want g=%b y=%b r=%b ph=%0d busy=%b",
                 n, green, yellow, red, phase, busy, it.g, it.y, it.r, it.ph, it.b);
      end
    end
  endtask

  initial begin
    res_n = 1'b0;
    en    = 1'b0;
    req   = 4'h0;
    test_reset();
    test_hold();
    test_maxout();
    test_gapout();
    test_back_to_back();
`ifndef TRAFFIC_FLASH_EN
    test_freeze();
`else
    test_flash();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Four-approach intersection phase scheduler. It shares the single green phase among four request sensors, using round-robin arbitration and minimum-green, gap-out and max-out timing. It sequences each served approach through green, yellow and all-red clearance, and drives one-hot lamp outputs for the signal heads.

## Interface
- `GREEN_MIN`, 4: minimum green cycles once granted (1..255)
- `GREEN_MAX`, 10: green cycles after which a contested green is forced off (GREEN_MIN..255)
- `YELLOW_T`, 2: yellow cycles (1..255)
- `ALLRED_T`, 1: all-red clearance cycles (1..255)
- `FLASH_T`, 4: half-period of flash mode, in cycles (1..255; used only with `TRAFFIC_FLASH_EN`)
- `clk`  in  1  clock; all state changes on its rising edge
- `res_n`  in  1  reset, synchronous, active-low
- `en`  in  1  run enable; low suspends normal sequencing
- `req`  in  4  level request per approach (bit i = approach i)
- `green`  out  4  one-hot green lamp, or zero
- `yellow`  out  4  yellow lamps
- `red`  out  4  red lamps
- `phase`  out  2  index of the approach most recently granted
- `busy`  out  1  high in GREEN, YELLOW or ALLRED

## Operation
- Clock, reset and synchronicity:
  - The block has one clock domain, `clk`.
  - `res_n` is synchronous and active-low: it is sampled only at the rising edge of `clk`, and low at that edge resets the block.
- Reset values:
  - Outputs: `green` = 0, `yellow` = 0, `red` = 4'hF, `phase` = 2'd3, `busy` = 0.
  - Internal: state IDLE, timer = 0.
  - `phase` = 3 makes approach 0 the highest priority after reset.
- Lamp rule: `red` = ~(`green` | `yellow`) in every state except flash mode. At most one approach is green or yellow at any time.
- The timer is 8 bits. It clears on every state entry and increments once per cycle while `en` = 1. In GREEN it saturates at 255.
- The round-robin pick is the first `req` bit found by scanning from `phase`+1 upward, modulo 4. The current approach is scanned last.
- IDLE:
  - All lamps red.
  - If `en` and any `req` bit is set: load `phase` with the round-robin pick and go to GREEN.
- GREEN (`green[phase]` = 1). Let "contested" mean that some `req` bit other than `phase` is set. Go to YELLOW when the timer is ≥ GREEN_MIN-1 and the approach is contested, and either:
  - gap-out: `req[phase]` = 0, or
  - max-out: the timer is ≥ GREEN_MAX-1.
- GREEN when uncontested: green holds indefinitely, even if `req[phase]` drops. No phase change is ever made without another request.
- YELLOW (`yellow[phase]` = 1): lasts exactly YELLOW_T cycles, then goes to ALLRED.
- ALLRED (all red, `busy` = 1): lasts exactly ALLRED_T cycles. Then:
  - if any `req` bit is set, take the round-robin pick and go to GREEN; the same approach may be picked again if it is the only requester;
  - otherwise go to IDLE.
- `en` = 0 (without `TRAFFIC_FLASH_EN`):
  - State, timer and all outputs freeze.
  - When `en` returns to 1, sequencing resumes from the same state and timer value.
- Simultaneous events:
  - Reset wins over everything.
  - `en` = 0 wins over any transition.
  - A request that arrives in the same cycle as the ALLRED exit is seen by the pick.

## Timing
- All outputs are registered.
- Decision latency is one cycle: if a condition is true at edge k, the new lamps are visible after edge k.
- Service sequence: `req[i]` first seen high in IDLE at edge k → `green[i]` = 1 from edge k.
- Minimum durations:
  - green is on for at least GREEN_MIN cycles;
  - a contested green with `req[phase]` still high lasts exactly GREEN_MAX cycles.
- From the end of green to the next green on another approach takes YELLOW_T + ALLRED_T cycles.
- Reset in the middle of any phase: the next cycle shows all red, IDLE, and `phase` = 3.

## Configuration
- Macro: `TRAFFIC_FLASH_EN`.
- When defined:
  - `en` = 0 enters the FLASH state: `green` = 0 and `red` = 0, and `yellow` = 4'hF and 4'h0 alternate every FLASH_T cycles, starting lit. `busy` = 0.
  - When `en` rises, the block goes to ALLRED for ALLRED_T cycles and then follows the normal ALLRED exit. `phase` is preserved.
- When undefined: the FLASH state is absent and `en` = 0 freezes the block as described in Operation.

## Test plan
- Reset, then `req` = 4'b0001 held for 30 cycles: `green` = 0001 from the first edge after the request, with no yellow ever shown.
- `req[0]` held, `req[2]` raised in green cycle 1:
  - `green[0]` for 10 cycles, then `yellow[0]` for 2, then all red for 1, then `green[2]`.
  - `phase` goes 0 → 2.
- Gap-out with `req[1]` pending:
  - `req[0]` drops in green cycle 1: green is held until cycle 4, then yellow.
  - `req[0]` drops in green cycle 6: yellow on the next cycle.
- `req` = 4'hF held: greens are served in the order 0, 1, 2, 3, 0, each for 10 cycles with 3 cycles of clearance between them.
- Freeze: `en` = 0 for 5 cycles during YELLOW → lamps and timer unchanged. On resume the remaining yellow cycles complete, and the total yellow time is 2 enabled cycles.
- Reset asserted mid-YELLOW → after the next edge all red, IDLE, `busy` = 0, and the next grant goes to approach 0. With `TRAFFIC_FLASH_EN` defined, `en` = 0 → `yellow` toggles between 4'hF and 4'h0 every 4 cycles.
